dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, data width.
REQ-002 The block SHALL have parameter ADDR_W, default 32, byte address width.
REQ-003 The block SHALL have parameter STARVE_MAX, default 4, consecutive debug losses before debug is forced to win.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset: clk in 1 (rising-edge clock); rstn in 1 (async active-low reset).
REQ-005 The block SHALL have the following CPU MEM-stage ports:
- cpu_req in 1, access request
- cpu_we in 1, write enable
- cpu_addr in ADDR_W, address
- cpu_wdata in DATA_W, write data
REQ-006 The block SHALL have the following CPU response ports:
- cpu_gnt out 1, access issued this cycle
- cpu_stall out 1, cpu_req and not cpu_gnt
- cpu_rvalid out 1, read data valid
- cpu_rdata out DATA_W, read data
REQ-007 The block SHALL have the following debug/loader ports:
- dbg_req in 1, access request, held until dbg_ack
- dbg_we in 1, write enable
- dbg_addr in ADDR_W, address
- dbg_wdata in DATA_W, write data
- dbg_ack out 1, completion pulse
- dbg_rdata out DATA_W, read data
REQ-008 The block SHALL have the following data memory ports:
- mem_en out 1, access strobe
- mem_we out 1, write strobe
- mem_addr out ADDR_W, address
- mem_wdata out DATA_W, write data
- mem_rdata in DATA_W, synchronous read data, valid the cycle after mem_en

Function
REQ-009 The block SHALL issue at most one memory access per cycle: mem_en=1 iff a requester is granted, with mem_we/addr/wdata driven combinationally from the winner.
REQ-010 Arbitration SHALL be decided combinationally each cycle from cpu_req, dbg_req, dbg_busy and starve_cnt.
REQ-011 dbg_busy SHALL be a register, set the cycle after a debug grant and cleared otherwise.
REQ-012 Debug SHALL be eligible only when dbg_req=1 and dbg_busy=0, so no double grant occurs in the ack cycle.
REQ-013 Priority: if only one requester is eligible, it SHALL win.
REQ-014 Priority: if both are eligible, CPU SHALL win while starve_cnt<STARVE_MAX, and debug SHALL win when starve_cnt==STARVE_MAX.
REQ-015 starve_cnt SHALL be ceil(log2(STARVE_MAX+1)) bits wide and SHALL increment when debug is eligible but loses.
REQ-016 starve_cnt SHALL clear to 0 on any debug grant or when dbg_req=0.
REQ-017 starve_cnt SHALL saturate at STARVE_MAX and never wrap.
REQ-018 cpu_gnt SHALL be combinational; cpu_stall SHALL equal cpu_req & ~cpu_gnt in the same cycle.
REQ-019 A CPU read granted in cycle t SHALL produce cpu_rvalid=1 in t+1 with cpu_rdata=mem_rdata; cpu_rvalid SHALL be 0 for CPU writes.
REQ-020 A debug access granted in cycle t SHALL produce dbg_ack=1 for exactly one cycle at t+1, for both reads and writes.
REQ-021 For a debug read, dbg_rdata SHALL equal mem_rdata at t+1 and hold that value until the next debug read ack.
REQ-022 cpu_rdata SHALL hold its last read value while cpu_rvalid=0.
REQ-023 A CPU access in cycle t+1 SHALL NOT corrupt the debug data of an access returned in t+1, and vice versa; return routing SHALL be registered per requester.
REQ-024 The debug requester MAY present a new request in the ack cycle; that request SHALL become eligible at t+2.
REQ-025 When neither requester is eligible: mem_en=0, mem_we=0, and starve_cnt is unchanged except as cleared by REQ-016.

Reset
REQ-026 While rstn=0 (asynchronously): cpu_rvalid=0, dbg_ack=0, dbg_busy=0, starve_cnt=0, cpu_rdata=0, dbg_rdata=0.
REQ-027 Reset asserted mid-access SHALL discard any pending rvalid/ack; no ack SHALL be emitted after reset release for pre-reset grants.
REQ-028 Combinational outputs (mem_*, cpu_gnt, cpu_stall) SHALL be forced to 0 while rstn=0.

Verification
REQ-029 Scenario: CPU read only, addr 0x10 holding 0x1234 -> mem_en=1 cycle t, cpu_rvalid=1 with cpu_rdata=0x1234 at t+1, cpu_stall=0 throughout.
REQ-030 Scenario: CPU and debug both requesting continuously, STARVE_MAX=4 -> CPU granted 4 cycles with cpu_stall=0, then debug granted on the 5th cycle with cpu_stall=1, dbg_ack next cycle, starve_cnt=0.
REQ-031 Scenario: debug write 0xDEADBEEF to 0x20, then debug read 0x20 issued in the ack cycle -> write ack at t+1, read granted t+2, dbg_ack with dbg_rdata=0xDEADBEEF at t+3.
REQ-032 Scenario: debug read granted at t while the CPU read of 0x30 (0x55) is granted at t+1 -> dbg_rdata correct at t+1, cpu_rvalid with 0x55 at t+2, no cross-routing.
REQ-033 Scenario: rstn pulsed low at t+1 after a debug grant at t -> dbg_ack stays 0, starve_cnt=0, and no ack after release.
REQ-034 Scenario: debug requests with CPU idle -> debug granted every other cycle (grant, ack, grant, ...), never granted in an ack cycle.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
//
// Bundles the three buses that meet at the data-memory arbiter:
//   - CPU MEM-stage request/response (cpu_*)
//   - debug/loader request/response  (dbg_*)
//   - single-port synchronous data memory (mem_*)
//
// Modports:
//   slave  : the arbiter's view. It receives requests and mem_rdata, and
//            drives grants, acks, read data and the memory strobes.
//   master : the surrounding system's view. It drives requests and mem_rdata,
//            and observes everything the arbiter produces.
//
// Parameters:
//   DATA_W : data width
//   ADDR_W : byte address width
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);

  // CPU MEM stage
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  // Debug / loader port; dbg_req is held until dbg_ack
  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_rdata;

  // Data memory; mem_rdata is valid the cycle after mem_en
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_ack, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_ack, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-port synchronous data memory between the CPU MEM stage
// and a debug/loader port. At most one access is issued per cycle.
//
// Arbitration (combinational, every cycle):
//   - debug is eligible only when dbg_req=1 and it is not in its ack cycle
//     (dbg_busy), so a held request is never granted twice;
//   - a lone eligible requester wins;
//   - with both eligible, the CPU wins until the debug side has lost
//     STARVE_MAX consecutive times, then debug wins once.
//
// Read data returns one cycle after the grant. Return routing is remembered
// per requester, so a CPU access issued in a debug ack cycle (or the reverse)
// never steers data to the wrong side. Each side's read data holds its last
// value between returns.
//
// Ports:
//   clk  : rising-edge clock
//   rstn : asynchronous active-low reset; also forces all combinational
//          outputs (mem_*, cpu_gnt, cpu_stall) low while asserted
//   bus  : dmem_arbiter_if.slave (CPU, debug and memory buses)
//
// Parameters:
//   DATA_W     : data width
//   ADDR_W     : byte address width
//   STARVE_MAX : consecutive debug losses before debug is forced to win
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           rstn,
  dmem_arbiter_if.slave  bus
);

  localparam int                CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // dbg_busy_reg marks the debug ack cycle: it is exactly the registered debug
  // grant, so it also serves directly as dbg_ack.
  logic              dbg_busy_reg;
  logic [CNT_W-1:0]  starve_cnt_reg;
  logic [CNT_W-1:0]  starve_cnt_next;

  // Per-requester return tags: a read is outstanding for this side
  logic              cpu_rd_pend_reg;
  logic              dbg_rd_pend_reg;

  // Last returned read data per side, shown while no return is in flight
  logic [DATA_W-1:0] cpu_rdata_hold_reg;
  logic [DATA_W-1:0] dbg_rdata_hold_reg;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic dbg_elig;
  logic starved;
  logic grant_cpu;
  logic grant_dbg;

  always_comb begin
    dbg_elig  = bus.dbg_req & ~dbg_busy_reg;
    starved   = (starve_cnt_reg == STARVE_LIM);
    // Debug wins when alone, or when both compete and it has starved out.
    grant_dbg = rstn & dbg_elig & (~bus.cpu_req | starved);
    grant_cpu = rstn & bus.cpu_req & ~grant_dbg;
  end

  // Starvation counter: clears on a debug grant or a dropped request, counts
  // up only on a lost eligible cycle, and never passes STARVE_MAX. A held
  // request during the ack cycle is not eligible, so the count just holds.
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (grant_dbg || !bus.dbg_req) begin
      starve_cnt_next = '0;
    end else if (dbg_elig && !starved) begin
      starve_cnt_next = starve_cnt_reg + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory request mux (winner drives the bus, zeros when idle)
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.mem_en    = grant_cpu | grant_dbg;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (grant_cpu) begin
      bus.mem_we    = bus.cpu_we;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end else if (grant_dbg) begin
      bus.mem_we    = bus.dbg_we;
      bus.mem_addr  = bus.dbg_addr;
      bus.mem_wdata = bus.dbg_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // CPU handshake
  // ---------------------------------------------------------------------------
  // grant_cpu is already low in reset, so the stall needs its own gate.
  assign bus.cpu_gnt   = grant_cpu;
  assign bus.cpu_stall = rstn & bus.cpu_req & ~grant_cpu;

  // ---------------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dbg_busy_reg    <= 1'b0;
      starve_cnt_reg  <= '0;
      cpu_rd_pend_reg <= 1'b0;
      dbg_rd_pend_reg <= 1'b0;
    end else begin
      dbg_busy_reg    <= grant_dbg;
      starve_cnt_reg  <= starve_cnt_next;
      cpu_rd_pend_reg <= grant_cpu & ~bus.cpu_we;
      dbg_rd_pend_reg <= grant_dbg & ~bus.dbg_we;
    end
  end

  // Capture the returning word into the owning side's hold register so it
  // stays visible after the return cycle. Debug writes leave dbg data alone.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cpu_rdata_hold_reg <= '0;
      dbg_rdata_hold_reg <= '0;
    end else begin
      if (cpu_rd_pend_reg) begin
        cpu_rdata_hold_reg <= bus.mem_rdata;
      end
      if (dbg_rd_pend_reg) begin
        dbg_rdata_hold_reg <= bus.mem_rdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Return path
  // ---------------------------------------------------------------------------
  // The memory's data only exists in the return cycle, so it is passed
  // straight through then and the hold register covers every other cycle.
  assign bus.cpu_rvalid = cpu_rd_pend_reg;
  assign bus.cpu_rdata  = cpu_rd_pend_reg ? bus.mem_rdata : cpu_rdata_hold_reg;
  assign bus.dbg_ack    = dbg_busy_reg;
  assign bus.dbg_rdata  = dbg_rd_pend_reg ? bus.mem_rdata : dbg_rdata_hold_reg;

endmodule
